// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the write-back stage has priority, a secondary unit is
// buffered in a small FIFO, and a starvation counter forces a one-cycle pipeline stall.
module rf_write_arbiter #(
    parameter int WORD         = 32,
    parameter int REG_AW       = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wb_we,
    input  logic [REG_AW-1:0]               wb_addr,
    input  logic [WORD-1:0]                 wb_data,
    input  logic                            sec_valid,
    output logic                            sec_ready,
    input  logic [REG_AW-1:0]               sec_addr,
    input  logic [WORD-1:0]                 sec_data,
    output logic                            rf_we,
    output logic [REG_AW-1:0]               rf_addr,
    output logic [WORD-1:0]                 rf_data,
    output logic                            pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = REG_AW + WORD;

    typedef enum logic {NORMAL, STALL} state_t;

    state_t            state, state_next;
    logic [SW-1:0]     starve_cnt, starve_next;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              fifo_empty;
    logic              push, pop;
    logic              grant_wb, grant_sec;

    assign fifo_empty = (count == '0);
    assign sec_ready  = (count < CW'(FIFO_DEPTH));
    assign push       = sec_valid & sec_ready;
    assign pop        = grant_sec;
    assign head       = fifo_mem[rd_ptr];
    assign pipe_stall = (state == STALL);
    assign fifo_count = count;

    // Secondary wins during the forced stall; otherwise write-back has priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_wb  = 1'b0;
        grant_sec = 1'b0;
        if (state == STALL && !fifo_empty) begin
            grant_sec = 1'b1;
        end else if (state == NORMAL && wb_we) begin
            grant_wb = 1'b1;
        end else if (!fifo_empty) begin
            grant_sec = 1'b1;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        state_next  = state;
        if (grant_sec || fifo_empty || state == STALL) begin
            starve_next = '0;
        end else if (grant_wb && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + SW'(1);
        end
        case (state)
            NORMAL:  if (starve_next == SW'(STARVE_LIMIT)) state_next = STALL;
            STALL:   state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state      <= state_next;
            starve_cnt <= starve_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {sec_addr, sec_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= grant_wb | grant_sec;
            if (grant_wb) begin
                rf_addr <= wb_addr;
                rf_data <= wb_data;
            end else if (grant_sec) begin
                rf_addr <= head[EW-1:WORD];
                rf_data <= head[WORD-1:0];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter: each scenario task drives vectors and
// compares the registered write port against hand-computed values.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        sec_valid = 1'b0;
    logic        sec_ready;
    logic [3:0]  sec_addr = '0;
    logic [31:0] sec_data = '0;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic        pipe_stall;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.WORD(32), .REG_AW(4), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_addr   (sec_addr),
        .sec_data   (sec_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pipe_stall (pipe_stall),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 4'd0 || rf_data !== 32'd0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h stall=%b, want 0/0/0/0",
                     rf_we, rf_addr, rf_data, pipe_stall);
        end
        checks++;
        if (fifo_count !== 2'd0 || sec_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got count=%0d ready=%b, want 0/1", fifo_count, sec_ready);
        end
    endtask

    task automatic test_wb_only();
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'h0000_00A5;
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd3 || rf_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL wb_only_write: got we=%b addr=%0d data=%h, want 1/3/000000a5", rf_we, rf_addr, rf_data);
        end
        wb_we = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 4'd3 || rf_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL wb_only_idle_hold: got we=%b addr=%0d data=%h, want 0/3/000000a5", rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_sec_only();
        sec_valid = 1'b1; sec_addr = 4'd7; sec_data = 32'hDEAD_BEEF;
        tick();
        sec_valid = 1'b0;
        checks++;
        if (fifo_count !== 2'd1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL sec_only_push: got count=%0d we=%b, want 1/0 (no bypass)", fifo_count, rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd7 || rf_data !== 32'hDEAD_BEEF || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL sec_only_write: got we=%b addr=%0d data=%h count=%0d, want 1/7/deadbeef/0",
                     rf_we, rf_addr, rf_data, fifo_count);
        end
    endtask

    task automatic test_idle();
        wb_we = 1'b0; sec_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0 || pipe_stall !== 1'b0 || fifo_count !== 2'd0 || rf_addr !== 4'd7) begin
                errors++;
                $display("FAIL idle_cycle%0d: got we=%b stall=%b count=%0d addr=%0d, want 0/0/0/7",
                         i, rf_we, pipe_stall, fifo_count, rf_addr);
            end
        end
    endtask

    task automatic test_full_fifo();
        wb_we = 1'b1; wb_addr = 4'd10; wb_data = 32'h0000_1010;
        sec_valid = 1'b1; sec_addr = 4'd12; sec_data = 32'h0000_0100;
        tick();
        sec_addr = 4'd13; sec_data = 32'h0000_0200;
        tick();
        checks++;
        if (fifo_count !== 2'd2 || sec_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got count=%0d ready=%b, want 2/0", fifo_count, sec_ready);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd10) begin
            errors++;
            $display("FAIL full_wb_priority: got we=%b addr=%0d, want 1/10", rf_we, rf_addr);
        end
        sec_addr = 4'd14; sec_data = 32'h0000_0300;
        tick();
        checks++;
        if (fifo_count !== 2'd2 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL full_reject: got count=%0d stall=%b, want 2/0", fifo_count, pipe_stall);
        end
        wb_we = 1'b0; sec_valid = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd12 || rf_data !== 32'h0000_0100 || fifo_count !== 2'd1) begin
            errors++;
            $display("FAIL full_drain0: got we=%b addr=%0d data=%h count=%0d, want 1/12/00000100/1",
                     rf_we, rf_addr, rf_data, fifo_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd13 || rf_data !== 32'h0000_0200 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL full_drain1: got we=%b addr=%0d data=%h count=%0d, want 1/13/00000200/0",
                     rf_we, rf_addr, rf_data, fifo_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL full_no_third: got we=%b addr=%0d, want we=0", rf_we, rf_addr);
        end
    endtask

    task automatic test_starvation();
        sec_valid = 1'b1; sec_addr = 4'd9; sec_data = 32'h0000_0999;
        tick();
        sec_valid = 1'b0;
        wb_we = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb_addr = 4'(i); wb_data = 32'h0000_5000 + 32'(i);
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== 4'(i) || pipe_stall !== (i == 4)) begin
                errors++;
                $display("FAIL starve_wb%0d: got we=%b addr=%0d stall=%b, want 1/%0d/%b",
                         i, rf_we, rf_addr, pipe_stall, i, (i == 4));
            end
        end
        wb_addr = 4'd5; wb_data = 32'h0000_5005;
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd9 || rf_data !== 32'h0000_0999 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_sec: got we=%b addr=%0d data=%h stall=%b, want 1/9/00000999/0",
                     rf_we, rf_addr, rf_data, pipe_stall);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 4'd5 || rf_data !== 32'h0000_5005) begin
            errors++;
            $display("FAIL starve_held: got we=%b addr=%0d data=%h, want 1/5/00005005", rf_we, rf_addr, rf_data);
        end
        wb_we = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b0 || fifo_count !== 2'd0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_after: got we=%b count=%0d stall=%b, want 0/0/0", rf_we, fifo_count, pipe_stall);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp_data [6];
        exp_data = '{32'h21, 32'h22, 32'h23, 32'h24, 32'h11, 32'h25};
        sec_valid = 1'b1; sec_addr = 4'd2; sec_data = 32'h11;
        tick();
        sec_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 4'd2;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) wb_data = 32'h21 + 32'(i);
            else       wb_data = 32'h25;
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== 4'd2 || rf_data !== exp_data[i]) begin
                errors++;
                $display("FAIL same_addr_grant%0d: got we=%b addr=%0d data=%h, want 1/2/%h",
                         i, rf_we, rf_addr, rf_data, exp_data[i]);
            end
        end
        wb_we = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_data !== 32'h25) begin
            errors++;
            $display("FAIL same_addr_last: got we=%b data=%h, want 0/00000025", rf_we, rf_data);
        end
    endtask

    task automatic test_reset_midstream();
        wb_we = 1'b1; wb_addr = 4'd6; wb_data = 32'h0000_0066;
        sec_valid = 1'b1; sec_addr = 4'd8; sec_data = 32'h0000_0088;
        tick();
        sec_addr = 4'd11; sec_data = 32'h0000_00BB;
        tick();
        sec_valid = 1'b0;
        checks++;
        if (fifo_count !== 2'd2 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got count=%0d we=%b, want 2/1", fifo_count, rf_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 4'd0 || rf_data !== 32'd0 || pipe_stall !== 1'b0 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_async: got we=%b addr=%0d data=%h stall=%b count=%0d, want all 0",
                     rf_we, rf_addr, rf_data, pipe_stall, fifo_count);
        end
        wb_we = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (sec_ready !== 1'b1 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_release: got ready=%b count=%0d, want 1/0", sec_ready, fifo_count);
        end
        repeat (2) begin
            tick();
            checks++;
            if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
                errors++;
                $display("FAIL midreset_discard: got we=%b count=%0d, want 0/0", rf_we, fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_sec_only();
        test_idle();
        test_full_fifo();
        test_starvation();
        test_same_addr();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Arbitrates the single register-file write port between two requesters.
- Requester 1 is the pipeline write-back stage (write_data / reg_write path), with priority.
- Requester 2 is a secondary multi-cycle unit (e.g. load-multiple or multiplier), buffered in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so that secondary writes always drain. The block sits between the write-back stage and the register file.

Parameters:
- WORD, 32, data width of a register write.
- REG_AW, 4, register address width (16 architectural registers).
- FIFO_DEPTH, 2, secondary request buffer depth (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive write-back grants tolerated while the FIFO is non-empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  write-back stage requests a register write.
- wb_addr  in  REG_AW  write-back destination register.
- wb_data  in  WORD  write-back data.
- sec_valid  in  1  secondary unit offers a write.
- sec_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH).
- sec_addr  in  REG_AW  secondary destination register.
- sec_data  in  WORD  secondary data.
- rf_we  out  1  registered register-file write enable.
- rf_addr  out  REG_AW  registered write address.
- rf_data  out  WORD  registered write data.
- pipe_stall  out  1  pipeline must hold; the write-back request this cycle is not consumed.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_we=0, rf_addr=0, rf_data=0, pipe_stall=0.
  - fifo_count=0, FIFO pointers 0, starve_cnt=0, state=NORMAL.
  - A reset mid-operation discards all FIFO contents.
- Enqueue: on a clock edge with sec_valid & sec_ready, push {sec_addr, sec_data}.
  - sec_ready uses the pre-edge count, so a push and a pop in the same cycle at full is not allowed (sec_ready=0).
  - There is no bypass: an entry pushed into an empty FIFO is grantable from the next cycle.
- Grant (per cycle, evaluated on current state):
  - state=STALL and FIFO non-empty → grant secondary (pop).
  - else if pipe_stall=0 and wb_we → grant write-back.
  - else if FIFO non-empty → grant secondary (pop).
  - else → no write.
- Outputs: the granted {addr, data} are registered onto rf_addr/rf_data with rf_we=1 at the next edge. Latency is 1 cycle request→rf_we. When nothing is granted, rf_we=0 and rf_addr/rf_data hold their previous values.
- Simultaneous push and pop on a non-empty FIFO: count is unchanged and order is preserved (FIFO order strict).
- Pointers wrap modulo FIFO_DEPTH.
- starve_cnt:
  - Increments on each write-back grant while the FIFO is non-empty.
  - Clears on any secondary grant or whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- State machine:
  - States: NORMAL, STALL. pipe_stall = (state==STALL), decoded from the state register.
  - NORMAL → STALL when starve_cnt reaches STARVE_LIMIT.
  - STALL → NORMAL after exactly one cycle; starve_cnt clears.
- During STALL, the write-back stage holds wb_we/wb_addr/wb_data. The held request is granted in the following NORMAL cycle and is never lost or duplicated.
- Same-address writes from both requesters are written in grant order; the last write wins. No merging.
- wb_we=0 with the FIFO empty for any number of cycles: rf_we=0, no state change.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with fifo_count=2 → all outputs 0 immediately (asynchronously). After release, sec_ready=1 and fifo_count=0.
- Write-back only: wb_we=1, wb_addr=3, wb_data=0x0000_00A5 for one cycle → next edge rf_we=1, rf_addr=3, rf_data=0xA5. Following cycle rf_we=0.
- Secondary only: one push of addr=7, data=0xDEAD_BEEF with wb_we=0 → fifo_count=1 after the edge. rf_we=1, rf_addr=7 on the edge after that. fifo_count returns to 0.
- Full FIFO: push 2 entries with wb_we held 1 → sec_ready=0 at count=2. A third sec_valid is not accepted; no entry is overwritten.
- Starvation: FIFO holds 1 entry (addr=9), wb_we=1 continuously with addresses 1,2,3,4,… → 4 write-back writes (addrs 1,2,3,4). Then pipe_stall=1 for exactly one cycle and rf_addr=9 is written. The held write-back request (addr 5) is written next. No address is skipped or repeated.
- Same address from both requesters: FIFO entry addr=2, data=0x11; then wb addr=2, data=0x22 with starvation forced → writes occur in grant order, and the final rf_data for addr 2 matches the last grant.
